// File: rtl/cn_bank_rd_sched_if.sv
`default_nettype none
// ====================================================================
// cn_bank_rd_sched_if : request batch, bank read ports, result batch
// Rev 1.0
// ====================================================================
interface cn_bank_rd_sched_if #(
  parameter int PAGE_W = 5,
  parameter int Q      = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [4*PAGE_W-1:0]   page_addr_in;
  logic [3:0]            bank_addr_in;
  logic                  bank0_rd_en;
  logic [PAGE_W-1:0]     bank0_page;
  logic [Q-1:0]          bank0_rdata;
  logic                  bank1_rd_en;
  logic [PAGE_W-1:0]     bank1_page;
  logic [Q-1:0]          bank1_rdata;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*Q-1:0]        msg_out;

  modport master (
    output in_valid, page_addr_in, bank_addr_in, bank0_rdata, bank1_rdata, out_ready,
    input  in_ready, bank0_rd_en, bank0_page, bank1_rd_en, bank1_page, out_valid, msg_out
  );

  modport slave (
    input  in_valid, page_addr_in, bank_addr_in, bank0_rdata, bank1_rdata, out_ready,
    output in_ready, bank0_rd_en, bank0_page, bank1_rd_en, bank1_page, out_valid, msg_out
  );
endinterface
`default_nettype wire

// File: rtl/cn_bank_rd_sched.sv
`default_nettype none
// ====================================================================
// cn_bank_rd_sched : issues a batch of four CN lookups to two LUT banks,
// serialising same-bank conflicts. Optional macro: SCHED_STAT_EN. Rev 1.0
// ====================================================================
module cn_bank_rd_sched #(
  parameter int PAGE_W = 5,
  parameter int Q      = 4,
  parameter int RD_LAT = 1,
  parameter int CNT_W  = 16
) (
  input  logic              sys_clk,
  input  logic              rstn,
  cn_bank_rd_sched_if.slave bus
`ifdef SCHED_STAT_EN
  ,
  output logic [CNT_W-1:0]  conflict_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic [PAGE_W-1:0] page_q   [4];
  logic [3:0]        bank_q;
  logic [3:0]        pending;
  logic [3:0]        pending_nxt;
  logic              tag_v    [2][RD_LAT];
  logic [1:0]        tag_i    [2][RD_LAT];
  logic              grant_v  [2];
  logic [1:0]        grant_i  [2];
  logic [2:0]        pend_cnt [2];
  logic              crowded  [2];
  logic              tags_busy;
  logic              rd_en_q  [2];
  logic [PAGE_W-1:0] page_out [2];
  logic [Q-1:0]      rdata    [2];
  logic [4*Q-1:0]    msg_q;
  logic              out_valid_q;
  logic              accept;

  assign rdata[0]         = bus.bank0_rdata;
  assign rdata[1]         = bus.bank1_rdata;
  assign accept           = (state == IDLE) && bus.in_valid;

  assign bus.in_ready     = (state == IDLE);
  assign bus.bank0_rd_en  = rd_en_q[0];
  assign bus.bank0_page   = page_out[0];
  assign bus.bank1_rd_en  = rd_en_q[1];
  assign bus.bank1_page   = page_out[1];
  assign bus.out_valid    = out_valid_q;
  assign bus.msg_out      = msg_q;

  // Scan from D down to A so the lowest pending port on each bank wins.
  always_comb begin
    pending_nxt = pending;
    for (int b = 0; b < 2; b++) begin
      grant_v[b]  = 1'b0;
      grant_i[b]  = 2'd0;
      pend_cnt[b] = 3'd0;
      for (int p = 3; p >= 0; p--) begin
        if (pending[p] && (bank_q[p] == b[0])) begin
          grant_v[b]  = 1'b1;
          grant_i[b]  = 2'(p);
          pend_cnt[b] = pend_cnt[b] + 3'd1;
        end
      end
      crowded[b] = (pend_cnt[b] >= 3'd2);
      if ((state == ISSUE) && grant_v[b]) begin
        pending_nxt[grant_i[b]] = 1'b0;
      end
    end
  end

  always_comb begin
    tags_busy = 1'b0;
    for (int b = 0; b < 2; b++) begin
      for (int s = 0; s < RD_LAT; s++) begin
        tags_busy = tags_busy | tag_v[b][s];
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid)        state_nxt = ISSUE;
      ISSUE:   if (pending_nxt == 4'd0) state_nxt = DRAIN;
      DRAIN:   if (!tags_busy)          state_nxt = OUT;
      OUT:     if (bus.out_ready)       state_nxt = IDLE;
      default:                          state_nxt = IDLE;
    endcase
  end

  // Tag pipes track which port each in-flight read belongs to.
  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      bank_q      <= 4'd0;
      pending     <= 4'd0;
      msg_q       <= '0;
      out_valid_q <= 1'b0;
      for (int p = 0; p < 4; p++) begin
        page_q[p] <= '0;
      end
      for (int b = 0; b < 2; b++) begin
        rd_en_q[b]  <= 1'b0;
        page_out[b] <= '0;
        for (int s = 0; s < RD_LAT; s++) begin
          tag_v[b][s] <= 1'b0;
          tag_i[b][s] <= 2'd0;
        end
      end
    end else begin
      out_valid_q <= (state_nxt == OUT);
      if (accept) begin
        for (int p = 0; p < 4; p++) begin
          page_q[p] <= bus.page_addr_in[p*PAGE_W +: PAGE_W];
        end
        bank_q  <= bus.bank_addr_in;
        pending <= 4'b1111;
      end else begin
        pending <= pending_nxt;
      end
      for (int b = 0; b < 2; b++) begin
        rd_en_q[b] <= (state == ISSUE) && grant_v[b];
        if ((state == ISSUE) && grant_v[b]) begin
          page_out[b] <= page_q[grant_i[b]];
        end
        if (tag_v[b][RD_LAT-1]) begin
          msg_q[int'(tag_i[b][RD_LAT-1]) * Q +: Q] <= rdata[b];
        end
        tag_v[b][0] <= (state == ISSUE) && grant_v[b];
        tag_i[b][0] <= grant_i[b];
        for (int s = 1; s < RD_LAT; s++) begin
          tag_v[b][s] <= tag_v[b][s-1];
          tag_i[b][s] <= tag_i[b][s-1];
        end
      end
    end
  end

`ifdef SCHED_STAT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else if ((state == ISSUE) && (crowded[0] || crowded[1]) && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign conflict_cnt = cnt_q;
`else
  logic unused_stat;
  assign unused_stat = crowded[0] | crowded[1] | (CNT_W > 0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_cn_bank_rd_sched.sv
`default_nettype none
// tb_cn_bank_rd_sched : directed and random batches on RD_LAT=1 and RD_LAT=2
// schedulers, checked against a batch-level model of grants, latency and results.
module tb_cn_bank_rd_sched;
  localparam int PW = 5;
  localparam int QW = 4;

  logic sys_clk = 1'b0;
  logic rstn;
  int   checks = 0;
  int   errors = 0;

  logic [PW-1:0] last_pg [2][2];
  int            exp_cnt [2];
  logic [3:0]    junk0, junk1, junk2, junk3;
  logic [3:0]    r20, r21;

  cn_bank_rd_sched_if #(.PAGE_W(PW), .Q(QW)) b1 ();
  cn_bank_rd_sched_if #(.PAGE_W(PW), .Q(QW)) b2 ();

`ifdef SCHED_STAT_EN
  logic [15:0] cnt1, cnt2;
`endif

  cn_bank_rd_sched #(.PAGE_W(PW), .Q(QW), .RD_LAT(1), .CNT_W(16)) dut1 (
    .sys_clk      (sys_clk),
    .rstn         (rstn),
    .bus          (b1.slave)
`ifdef SCHED_STAT_EN
    ,
    .conflict_cnt (cnt1)
`endif
  );

  cn_bank_rd_sched #(.PAGE_W(PW), .Q(QW), .RD_LAT(2), .CNT_W(16)) dut2 (
    .sys_clk      (sys_clk),
    .rstn         (rstn),
    .bus          (b2.slave)
`ifdef SCHED_STAT_EN
    ,
    .conflict_cnt (cnt2)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  // Banks: bank0 returns page[3:0], bank1 returns ~page[3:0]; noise when not reading.
  always @(negedge sys_clk) begin
    junk0 = 4'($urandom);
    junk1 = 4'($urandom);
    junk2 = 4'($urandom);
    junk3 = 4'($urandom);
  end

  assign b1.bank0_rdata = b1.bank0_rd_en ? b1.bank0_page[3:0]  : junk0;
  assign b1.bank1_rdata = b1.bank1_rd_en ? ~b1.bank1_page[3:0] : junk1;

  always @(posedge sys_clk) begin
    r20 <= b2.bank0_rd_en ? b2.bank0_page[3:0]  : junk2;
    r21 <= b2.bank1_rd_en ? ~b2.bank1_page[3:0] : junk3;
  end
  assign b2.bank0_rdata = r20;
  assign b2.bank1_rdata = r21;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] bank_obs(input int l);
    if (l == 1) return {b1.bank0_rd_en, b1.bank0_page, b1.bank1_rd_en, b1.bank1_page};
    return {b2.bank0_rd_en, b2.bank0_page, b2.bank1_rd_en, b2.bank1_page};
  endfunction

  function automatic logic out_valid_obs(input int l);
    return (l == 1) ? b1.out_valid : b2.out_valid;
  endfunction

  function automatic logic in_ready_obs(input int l);
    return (l == 1) ? b1.in_ready : b2.in_ready;
  endfunction

  function automatic logic [15:0] msg_obs(input int l);
    return (l == 1) ? b1.msg_out : b2.msg_out;
  endfunction

`ifdef SCHED_STAT_EN
  function automatic logic [15:0] cnt_obs(input int l);
    return (l == 1) ? cnt1 : cnt2;
  endfunction
`endif

  task automatic set_in(input int l, input logic v, input logic [19:0] pg, input logic [3:0] bk);
    if (l == 1) begin
      b1.in_valid = v; b1.page_addr_in = pg; b1.bank_addr_in = bk;
    end else begin
      b2.in_valid = v; b2.page_addr_in = pg; b2.bank_addr_in = bk;
    end
  endtask

  task automatic set_ready(input int l, input logic r);
    if (l == 1) b1.out_ready = r;
    else        b2.out_ready = r;
  endtask

  function automatic logic [15:0] exp_msg(input logic [19:0] pg, input logic [3:0] bk);
    logic [15:0] m;
    m = '0;
    for (int p = 0; p < 4; p++)
      m[p*QW +: QW] = bk[p] ? ~pg[p*PW +: QW] : pg[p*PW +: QW];
    return m;
  endfunction

  // Cycles in which some bank still has two or more requests queued.
  function automatic int conf_inc(input logic [3:0] bk);
    int c1, c0, n, inc;
    c1 = $countones(bk);
    c0 = 4 - c1;
    n  = (c0 > c1) ? c0 : c1;
    inc = 0;
    for (int k = 0; k < n; k++)
      if ((c0 - k >= 2) || (c1 - k >= 2)) inc++;
    return inc;
  endfunction

  task automatic run_batch(input int l, input logic [19:0] pg, input logic [3:0] bk, input int hold);
    int          cnt [2];
    int          lst [2][4];
    int          n;
    int          b;
    logic [15:0] emsg;
    logic [PW-1:0] ep [2];
    logic        ee [2];
    cnt[0] = 0; cnt[1] = 0;
    for (int p = 0; p < 4; p++) begin
      b = int'(bk[p]);
      lst[b][cnt[b]] = p;
      cnt[b]++;
    end
    n    = (cnt[0] > cnt[1]) ? cnt[0] : cnt[1];
    emsg = exp_msg(pg, bk);

    check("in_ready_idle", 64'(in_ready_obs(l)), 64'd1);
    set_in(l, 1'b1, pg, bk);
    @(posedge sys_clk); #1;
    set_in(l, 1'b0, 20'($urandom), 4'($urandom));
    for (int k = 1; k <= n + l + 1; k++) begin
      @(posedge sys_clk); #1;
      for (int bb = 0; bb < 2; bb++) begin
        ee[bb] = (k <= cnt[bb]);
        if (k <= cnt[bb])    ep[bb] = pg[lst[bb][k-1]*PW +: PW];
        else if (cnt[bb] > 0) ep[bb] = pg[lst[bb][cnt[bb]-1]*PW +: PW];
        else                  ep[bb] = last_pg[l-1][bb];
      end
      check("bank_issue", 64'(bank_obs(l)), 64'({ee[0], ep[0], ee[1], ep[1]}));
      check("out_valid_timing", 64'(out_valid_obs(l)), 64'(k == n + l + 1));
    end
    check("msg_out", 64'(msg_obs(l)), 64'(emsg));
    check("in_ready_busy", 64'(in_ready_obs(l)), 64'd0);
    for (int h = 0; h < hold; h++) begin
      set_in(l, 1'b1, 20'($urandom), 4'($urandom));
      @(posedge sys_clk); #1;
      check("bp_out_valid", 64'(out_valid_obs(l)), 64'd1);
      check("bp_msg_out", 64'(msg_obs(l)), 64'(emsg));
      check("bp_in_ready", 64'(in_ready_obs(l)), 64'd0);
    end
    set_in(l, 1'b0, 20'($urandom), 4'($urandom));
    set_ready(l, 1'b1);
    @(posedge sys_clk); #1;
    check("handshake_out_valid", 64'(out_valid_obs(l)), 64'd0);
    check("handshake_in_ready", 64'(in_ready_obs(l)), 64'd1);
    set_ready(l, 1'b0);
    for (int bb = 0; bb < 2; bb++)
      if (cnt[bb] > 0) last_pg[l-1][bb] = pg[lst[bb][cnt[bb]-1]*PW +: PW];
    exp_cnt[l-1] += conf_inc(bk);
`ifdef SCHED_STAT_EN
    check("conflict_cnt", 64'(cnt_obs(l)), 64'(exp_cnt[l-1]));
`endif
  endtask

  task automatic back_to_back();
    logic [15:0] q [$];
    logic [3:0]  pats [6];
    logic [19:0] pg;
    logic [3:0]  bk;
    logic        pend;
    int          acc, got;
    logic [15:0] front;
    pats = '{4'b1010, 4'b0101, 4'b0011, 4'b1100, 4'b0110, 4'b1001};
    pg   = 20'($urandom);
    bk   = pats[$urandom_range(5, 0)];
    acc  = 0; got = 0;
    check("b2b_start_idle", 64'(b1.in_ready), 64'd1);
    set_in(1, 1'b1, pg, bk);
    set_ready(1, 1'b1);
    q.push_back(exp_msg(pg, bk)); acc++; exp_cnt[0] += conf_inc(bk);
    pend = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(posedge sys_clk); #1;
      if (pend) begin
        pg = 20'($urandom);
        bk = pats[$urandom_range(5, 0)];
        set_in(1, (c < 40), pg, bk);
        pend = 1'b0;
      end
      if (b1.out_valid) begin
        check("b2b_expected_output", 64'(q.size() > 0), 64'd1);
        if (q.size() > 0) begin
          front = q.pop_front();
          check("b2b_msg_out", 64'(b1.msg_out), 64'(front));
        end
        got++;
      end
      if (b1.in_ready && b1.in_valid) begin
        q.push_back(exp_msg(pg, bk)); acc++; exp_cnt[0] += conf_inc(bk);
        pend = 1'b1;
      end
    end
    set_in(1, 1'b0, '0, '0);
    set_ready(1, 1'b0);
    check("b2b_queue_drained", 64'(q.size()), 64'd0);
    check("b2b_result_count", 64'(got), 64'(acc));
`ifdef SCHED_STAT_EN
    check("b2b_conflict_cnt", 64'(cnt1), 64'(exp_cnt[0]));
`endif
  endtask

  initial begin
    rstn = 1'b0;
    set_in(1, 1'b0, '0, '0);
    set_in(2, 1'b0, '0, '0);
    set_ready(1, 1'b0);
    set_ready(2, 1'b0);
    for (int l = 0; l < 2; l++) begin
      exp_cnt[l] = 0;
      for (int b = 0; b < 2; b++) last_pg[l][b] = '0;
    end
    repeat (3) @(posedge sys_clk);
    #1;
    for (int l = 1; l <= 2; l++) begin
      check("reset_bank", 64'(bank_obs(l)), 64'd0);
      check("reset_out_valid", 64'(out_valid_obs(l)), 64'd0);
      check("reset_msg_out", 64'(msg_obs(l)), 64'd0);
      check("reset_in_ready", 64'(in_ready_obs(l)), 64'd1);
`ifdef SCHED_STAT_EN
      check("reset_conflict_cnt", 64'(cnt_obs(l)), 64'd0);
`endif
    end
    rstn = 1'b1;
    @(posedge sys_clk); #1;

    run_batch(1, {5'd31, 5'd12, 5'd7, 5'd3}, 4'b1010, 0);
    check("balanced_msg_lat1", 64'(msg_obs(1)), 64'h0C83);
    run_batch(1, 20'($urandom), 4'b0000, 0);
    run_batch(1, 20'($urandom), 4'($urandom), 5);
    for (int i = 0; i < 4; i++)
      run_batch(1, 20'($urandom), 4'($urandom), int'($urandom_range(3, 0)));
    run_batch(2, {5'd31, 5'd12, 5'd7, 5'd3}, 4'b1010, 0);
    check("balanced_msg_lat2", 64'(msg_obs(2)), 64'h0C83);

    // Reset during the first ISSUE cycle.
    set_in(1, 1'b1, 20'($urandom), 4'b0110);
    @(posedge sys_clk); #1;
    set_in(1, 1'b0, '0, '0);
    rstn = 1'b0;
    @(posedge sys_clk); #1;
    check("midrst_bank", 64'(bank_obs(1)), 64'd0);
    check("midrst_out_valid", 64'(out_valid_obs(1)), 64'd0);
    check("midrst_msg_out", 64'(msg_obs(1)), 64'd0);
    check("midrst_in_ready", 64'(in_ready_obs(1)), 64'd1);
    rstn = 1'b1;
    for (int l = 0; l < 2; l++) begin
      exp_cnt[l] = 0;
      for (int b = 0; b < 2; b++) last_pg[l][b] = '0;
    end
    repeat (3) begin
      @(posedge sys_clk); #1;
      check("midrst_stale_msg", 64'(msg_obs(1)), 64'd0);
      check("midrst_stale_valid", 64'(out_valid_obs(1)), 64'd0);
    end
`ifdef SCHED_STAT_EN
    check("midrst_conflict_cnt", 64'(cnt_obs(1)), 64'd0);
`endif

    back_to_back();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
